// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures the high time of a servo/RC PWM input and
// converts it to a position code (2^PRESCALE_SHIFT clk cycles per LSB).
// Optional input glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module servo_pwm_capture #(
   parameter int unsigned PRESCALE_SHIFT = 9,
   parameter int unsigned POS_W          = 10,
   parameter int unsigned CNT_W          = 22,
   parameter int unsigned TIMEOUT_CYCLES = 2097152,
   parameter int unsigned GLITCH_CYCLES  = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             pwm_in,
   output logic [POS_W-1:0] pos,
   output logic             pos_strobe,
   output logic             pos_valid,
   output logic             signal_lost
);

   localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] PosMax     = CNT_W'((2 ** POS_W) - 1);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   // Pipeline must reflect the real input (sync + filter + delayed copy).
   localparam int unsigned WarmCycles = 3 + GLITCH_CYCLES;
   localparam int unsigned GlW        = $clog2(GLITCH_CYCLES + 1);
`else
   localparam int unsigned WarmCycles = 3;
`endif
   localparam int unsigned WarmW = $clog2(WarmCycles + 1);

   typedef enum logic [1:0] {StIdle, StArmed, StHigh} state_e;

   logic             s1_q, s2_q, s3_q;
   logic             lvl, rise, fall;
   logic [WarmW-1:0] warm_q;
   logic             warm_done;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] code_full;
   logic [POS_W-1:0] pos_sat, pos_d;
   logic             strobe_d, valid_d, lost_d;

   // Two-flop synchroniser on the raw input.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= pwm_in;
         s2_q <= s1_q;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic           flt_q, flt_d;
   logic [GlW-1:0] gcnt_q, gcnt_d;

   // Accept a new level only after GLITCH_CYCLES consecutive samples of it.
   always_comb begin
      flt_d  = flt_q;
      gcnt_d = '0;
      if (s2_q != flt_q) begin
         if (gcnt_q == GlW'(GLITCH_CYCLES - 1)) begin
            flt_d = s2_q;
         end else begin
            gcnt_d = gcnt_q + 1'b1;
         end
      end
   end

   // Filter state register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         flt_q  <= 1'b0;
         gcnt_q <= '0;
      end else begin
         flt_q  <= flt_d;
         gcnt_q <= gcnt_d;
      end
   end

   assign lvl = flt_q;
`else
   assign lvl = s2_q;
`endif

   // Delayed copy of the working level for edge detection (equals s2 delayed
   // by one when unfiltered).
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s3_q <= 1'b0;
      end else begin
         s3_q <= lvl;
      end
   end

   assign rise = lvl & ~s3_q;
   assign fall = ~lvl & s3_q;

   // Warm-up counter: the reset zeros in the pipeline must not look like a
   // low phase, otherwise a pulse in progress at reset release would publish.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         warm_q <= '0;
      end else if (!warm_done) begin
         warm_q <= warm_q + 1'b1;
      end
   end

   assign warm_done = (warm_q == WarmW'(WarmCycles));

   // Saturating conversion of the high-time count to a position code.
   always_comb begin
      code_full = hi_cnt_q >> PRESCALE_SHIFT;
      pos_sat   = (code_full > PosMax) ? '1 : code_full[POS_W-1:0];
   end

   // Next-state, counters and output updates; publish overrides loss.
   always_comb begin
      state_d  = state_q;
      hi_cnt_d = hi_cnt_q;
      pos_d    = pos;
      strobe_d = 1'b0;
      valid_d  = pos_valid;
      lost_d   = signal_lost;

      if (rise) begin
         per_cnt_d = '0;
      end else if (per_cnt_q == TimeoutVal) begin
         per_cnt_d = TimeoutVal;
      end else begin
         per_cnt_d = per_cnt_q + 1'b1;
      end

      if (per_cnt_d == TimeoutVal) begin
         valid_d = 1'b0;
         lost_d  = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            hi_cnt_d = '0;
            if (warm_done && !lvl) begin
               state_d = StArmed;
            end
         end
         StArmed: begin
            if (rise) begin
               state_d  = StHigh;
               hi_cnt_d = CNT_W'(1);
            end
         end
         StHigh: begin
            if (fall) begin
               state_d  = StArmed;
               pos_d    = pos_sat;
               strobe_d = 1'b1;
               valid_d  = 1'b1;
               lost_d   = 1'b0;
            end else if (lvl) begin
               hi_cnt_d = hi_cnt_q + 1'b1;
               // Stuck high: abandon the pulse without publishing.
               if (hi_cnt_d == TimeoutVal) begin
                  state_d  = StIdle;
                  hi_cnt_d = '0;
                  valid_d  = 1'b0;
                  lost_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= StIdle;
         hi_cnt_q    <= '0;
         per_cnt_q   <= '0;
         pos         <= '0;
         pos_strobe  <= 1'b0;
         pos_valid   <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         state_q     <= state_d;
         hi_cnt_q    <= hi_cnt_d;
         per_cnt_q   <= per_cnt_d;
         pos         <= pos_d;
         pos_strobe  <= strobe_d;
         pos_valid   <= valid_d;
         signal_lost <= lost_d;
      end
   end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Scoreboard bench for servo_pwm_capture. Scaled parameters keep the run
// short: 8 cycles/LSB, 8-bit codes, 4096-cycle timeout.
module tb_servo_pwm_capture;

   localparam int unsigned SH   = 3;
   localparam int unsigned PW   = 8;
   localparam int unsigned CW   = 13;
   localparam int unsigned TO   = 4096;
   localparam int unsigned GL   = 4;
   localparam int          MAXC = 255;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int          LATG = GL;
`else
   localparam int          LATG = 0;
`endif

   typedef struct {
      int pos;
      int cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          pwm_in;
   logic [PW-1:0] pos;
   logic          pos_strobe;
   logic          pos_valid;
   logic          signal_lost;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   rise_cyc = 0;
   exp_t sb_q[$];

   servo_pwm_capture #(
      .PRESCALE_SHIFT (SH),
      .POS_W          (PW),
      .CNT_W          (CW),
      .TIMEOUT_CYCLES (TO),
      .GLITCH_CYCLES  (GL)
   ) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .pwm_in      (pwm_in),
      .pos         (pos),
      .pos_strobe  (pos_strobe),
      .pos_valid   (pos_valid),
      .signal_lost (signal_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_code(input int hi);
      return ((hi >> SH) > MAXC) ? MAXC : (hi >> SH);
   endfunction

   function automatic exp_t mk(input int p, input int c);
      exp_t e;
      e.pos = p;
      e.cyc = c;
      return e;
   endfunction

   // Drive hi_n high samples then lo_n low; queue the expected capture.
   task automatic pulse(input int hi_n, input int lo_n, input bit publish);
      @(negedge clk);
      pwm_in   = 1'b1;
      rise_cyc = cyc;
      repeat (hi_n) @(negedge clk);
      pwm_in = 1'b0;
      // first low sample at edge cyc+1, update two edges later
      if (publish) sb_q.push_back(mk(exp_code(hi_n), cyc + 3 + LATG));
      repeat (lo_n) @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (clr_n && pos_strobe) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got pos=%0d at cycle %0d, expected no strobe",
                     pos, cyc);
         end else begin
            e = sb_q.pop_front();
            check("pos", int'(pos), e.pos);
            check("strobe_cycle", cyc, e.cyc);
            check("valid_on_strobe", int'(pos_valid), 1);
            check("lost_on_strobe", int'(signal_lost), 0);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int c;
      clr_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pos", int'(pos), 0);
      check("rst_strobe", int'(pos_strobe), 0);
      check("rst_valid", int'(pos_valid), 0);
      check("rst_lost", int'(signal_lost), 1);
      clr_n = 1'b1;
      repeat (20) @(negedge clk);

      // Nominal pulse, code 150.
      pulse(150 * 8, 2000, 1'b1);
      check("valid_after_capture", int'(pos_valid), 1);
      check("lost_after_capture", int'(signal_lost), 0);

      // Code sweep: sub-LSB, 1 LSB, truncation, mid, full-scale, saturation.
      pulse(5, 200, 1'b1);
      pulse(8, 200, 1'b1);
      pulse(15, 200, 1'b1);
      pulse(127 * 8, 200, 1'b1);
      pulse(255 * 8, 200, 1'b1);
      pulse(400 * 8, 200, 1'b1);

      // Reset released while input high: that pulse must not publish.
      @(negedge clk);
      pwm_in = 1'b1;
      clr_n  = 1'b0;
      repeat (5) @(negedge clk);
      clr_n = 1'b1;
      repeat (800) @(negedge clk);
      pwm_in = 1'b0;
      repeat (200) @(negedge clk);
      check("partial_pulse_valid", int'(pos_valid), 0);
      check("partial_pulse_lost", int'(signal_lost), 1);
      pulse(50 * 8, 200, 1'b1);

      // Input held low: loss exactly TO edges after per_cnt cleared.
      pulse(60 * 8, 10, 1'b1);
      wait_until(rise_cyc + 2 + TO + LATG);
      check("lowto_valid_before", int'(pos_valid), 1);
      @(negedge clk);
      check("lowto_valid", int'(pos_valid), 0);
      check("lowto_lost", int'(signal_lost), 1);
      check("lowto_pos_kept", int'(pos), 60);
      pulse(61 * 8, 200, 1'b1);
      check("restore_valid", int'(pos_valid), 1);

      // Input stuck high: loss when hi_cnt reaches TO, no strobe.
      @(negedge clk);
      pwm_in = 1'b1;
      c      = cyc;
      wait_until(c + 1 + TO + LATG);
      check("hito_valid_before", int'(pos_valid), 1);
      @(negedge clk);
      check("hito_valid", int'(pos_valid), 0);
      check("hito_lost", int'(signal_lost), 1);
      check("hito_pos_kept", int'(pos), 61);
      pwm_in = 1'b0;
      repeat (50) @(negedge clk);
      pulse(90 * 8, 200, 1'b1);
      check("restore2_valid", int'(pos_valid), 1);
      check("restore2_lost", int'(signal_lost), 0);

      // Asynchronous reset in the middle of a high phase.
      @(negedge clk);
      pwm_in = 1'b1;
      repeat (300) @(negedge clk);
      @(posedge clk);
      #2;
      clr_n = 1'b0;
      #1;
      check("async_pos", int'(pos), 0);
      check("async_strobe", int'(pos_strobe), 0);
      check("async_valid", int'(pos_valid), 0);
      check("async_lost", int'(signal_lost), 1);
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      repeat (200) @(negedge clk);
      pwm_in = 1'b0;
      repeat (100) @(negedge clk);
      check("after_async_valid", int'(pos_valid), 0);
      pulse(77 * 8, 200, 1'b1);

      // Short spike, then a pulse with a 2-cycle dropout.
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      pulse(3, 200, 1'b0);
      @(negedge clk);
      pwm_in = 1'b1;
      repeat (800) @(negedge clk);
      pwm_in = 1'b0;
      repeat (2) @(negedge clk);
      pwm_in = 1'b1;
      repeat (800) @(negedge clk);
      pwm_in = 1'b0;
      sb_q.push_back(mk(200, cyc + 3 + LATG));
      repeat (200) @(negedge clk);
`else
      pulse(3, 200, 1'b1);
`endif

      repeat (50) @(negedge clk);
      check("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
